fleet_tactics_ctrl: RTL and testbench
=====================================

Name: fleet_tactics_ctrl

Overview:
Parametrised next-generation opponent controller for the space-battle showdown harness. It replaces the stateless per-ship steering/fire logic with:
- a per-enemy tracker that dead-reckons cloaked enemies;
- a per-ship tactical FSM (PATROL/ENGAGE/EVADE/RECHARGE/DEAD);
- a fire cooldown counter.
All actions are registered outputs and feed the showdown arbiter unchanged.

Parameters:
NUM_SHIPS, 3, own ships and enemy ships (equal counts)
COORD_W, 8, signed coordinate width
ACC_W, 4, signed acceleration output width
MAX_ACC, 2, acceleration magnitude clamp
FIRE_COST, 30, energy required to attempt fire
SHIELD_COST, 25, energy required to attempt shield
CLOAK_COST, 15, energy required to attempt cloak
FIRE_RANGE, 48, Manhattan distance at or below which ENGAGE is allowed
DANGER_RANGE, 12, Manhattan distance at or below which EVADE is forced
RECHARGE_LO, 20, enter RECHARGE when energy < this
RECHARGE_HI, 60, leave RECHARGE when energy >= this
FIRE_COOLDOWN, 2, cycles blocked after each fire attempt
STALE_LIMIT, 6, cloaked cycles after which a track is dropped
BORDER, 32, arena half-width
MARGIN, 2, border guard band

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
x, y  in  NUM_SHIPS*COORD_W  own ship positions, signed, packed (ship i at [i*COORD_W +: COORD_W])
energy  in  NUM_SHIPS*8  own ship energy, unsigned
destroyed  in  NUM_SHIPS  own ship destroyed
enemy_x, enemy_y  in  NUM_SHIPS*COORD_W  enemy positions (frozen while cloaked)
enemy_cloaked  in  NUM_SHIPS  enemy cloaked
enemy_destroyed  in  NUM_SHIPS  enemy destroyed
x_a, y_a  out  NUM_SHIPS*ACC_W  attempted acceleration, signed
attempt_fire, attempt_shield, attempt_cloak  out  NUM_SHIPS  action attempts
fire_dir  out  NUM_SHIPS*2  0=+x, 1=-y, 2=-x, 3=+y
state_dbg  out  NUM_SHIPS*3  current FSM state per ship

Behaviour:
- Reset is synchronous and active-high on clock clk. On reset:
  - all outputs go to 0;
  - all FSMs go to PATROL;
  - cooldown counters clear to 0;
  - tracks clear: valid=0, vel=0, age=0.
- Enemy tracker, one per enemy, updated each cycle.
  - Visible (not cloaked, not destroyed): pos <= input, vel <= input - previous pos (saturated to ±7), age <= 0, valid <= 1.
  - Cloaked: pos <= pos + vel, saturated to ±(BORDER-1); age increments and saturates at STALE_LIMIT; valid <= 0 when age reaches STALE_LIMIT.
  - Destroyed: valid <= 0, sticky until reset.
  - On the first visible cycle after reset, vel = 0.
- Distances: Manhattan, computed in COORD_W+2 bits, no wrap.
- Target selection per ship: minimum distance among valid tracks, lead point = pos + vel. Ties go to the lowest enemy index. No valid track means no target.
- fire_dir comes from the lead vector (dx, dy):
  - |dx| >= |dy|: 0 if dx >= 0, else 2;
  - otherwise: 3 if dy > 0, else 1.
- FSM per ship, re-evaluated every cycle. Priority order: DEAD > EVADE > RECHARGE > ENGAGE > PATROL.
  - DEAD: entered when destroyed=1; sticky until reset. All outputs 0.
  - EVADE: any valid track within DANGER_RANGE.
    - attempt_shield if energy >= SHIELD_COST; else attempt_cloak if energy >= CLOAK_COST.
    - Accelerate away from the nearest track, ±MAX_ACC per axis (an axis with 0 delta gets 0).
  - RECHARGE: entered when energy < RECHARGE_LO; held until energy >= RECHARGE_HI, unless EVADE preempts. No fire. Accelerate toward the origin with sign(-pos)*1.
  - ENGAGE: target within FIRE_RANGE and energy >= FIRE_COST.
    - attempt_fire=1 only when cooldown==0. Cooldown loads FIRE_COOLDOWN on that same edge and decrements to 0 otherwise.
    - Steer toward the lead point, clamped to ±MAX_ACC.
  - PATROL: steer toward the target clamped to ±1, or 0 with no target. No actions.
- Border override, all states except DEAD:
  - pos >= BORDER-MARGIN forces that axis to -MAX_ACC;
  - pos <= -(BORDER-MARGIN) forces that axis to +MAX_ACC.
- Latency: all outputs are registered, 1 cycle after the inputs. state_dbg shows the state that produced the current outputs.
- Reset asserted mid-cooldown or mid-track clears everything on the next edge; outputs are 0 the cycle after.

Test Plan:
1. Reset, then one enemy at (20,0) visible, own at (0,0), energy 100 -> ship0 ENGAGE, attempt_fire=1, fire_dir=0, x_a=+2. Next cycle attempt_fire=0, then 0, then 1 again (cooldown 2).
2. Enemy at (5,3) -> EVADE, attempt_shield=1, x_a=-2, y_a=-2. Same position with energy 20 -> attempt_cloak=1, shield=0.
3. Enemy visible at (10,0) then (12,0), then cloaked for 3 cycles -> track pos 14, 16, 18. Cloaked through STALE_LIMIT=6 -> track invalid, ship returns to PATROL with x_a=0.
4. Energy drops 25 -> 19 -> RECHARGE, no fire. Energy 59 -> stays RECHARGE. Energy 60 -> ENGAGE. Enemy at distance 10 while in RECHARGE -> EVADE.
5. Own x=30, enemy at (40,0) -> x_a=-2 (border override beats steering). destroyed=1 -> DEAD, all outputs 0, stays DEAD after destroyed deasserts.
6. Two enemies equidistant at (10,0) and (0,-10) -> enemy 0 targeted, fire_dir=0. Enemy 0 destroyed -> fire_dir=1.

Source files
------------

// File: rtl/fleet_tactics_ctrl.sv
// fleet_tactics_ctrl: per-ship tactical opponent controller.
// This module tracks each enemy and dead-reckons it while the enemy is cloaked.
// It selects the nearest valid track as the target.
// A PATROL/ENGAGE/EVADE/RECHARGE/DEAD state machine then drives registered steering and action attempts.
module fleet_tactics_ctrl #(
    parameter int NUM_SHIPS     = 3,
    parameter int COORD_W       = 8,
    parameter int ACC_W         = 4,
    parameter int MAX_ACC       = 2,
    parameter int FIRE_COST     = 30,
    parameter int SHIELD_COST   = 25,
    parameter int CLOAK_COST    = 15,
    parameter int FIRE_RANGE    = 48,
    parameter int DANGER_RANGE  = 12,
    parameter int RECHARGE_LO   = 20,
    parameter int RECHARGE_HI   = 60,
    parameter int FIRE_COOLDOWN = 2,
    parameter int STALE_LIMIT   = 6,
    parameter int BORDER        = 32,
    parameter int MARGIN        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SHIPS*COORD_W-1:0]   x_i,
    input  logic [NUM_SHIPS*COORD_W-1:0]   y_i,
    input  logic [NUM_SHIPS*8-1:0]         energy_i,
    input  logic [NUM_SHIPS-1:0]           destroyed_i,
    input  logic [NUM_SHIPS*COORD_W-1:0]   enemy_x_i,
    input  logic [NUM_SHIPS*COORD_W-1:0]   enemy_y_i,
    input  logic [NUM_SHIPS-1:0]           enemy_cloaked_i,
    input  logic [NUM_SHIPS-1:0]           enemy_destroyed_i,
    output logic [NUM_SHIPS*ACC_W-1:0]     x_a_o,
    output logic [NUM_SHIPS*ACC_W-1:0]     y_a_o,
    output logic [NUM_SHIPS-1:0]           attempt_fire_o,
    output logic [NUM_SHIPS-1:0]           attempt_shield_o,
    output logic [NUM_SHIPS-1:0]           attempt_cloak_o,
    output logic [NUM_SHIPS*2-1:0]         fire_dir_o,
    output logic [NUM_SHIPS*3-1:0]         state_dbg_o
);

    localparam int CW    = COORD_W;
    localparam int DW    = COORD_W + 2;
    localparam int AGE_W = $clog2(STALE_LIMIT + 1);
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);

    typedef logic signed [CW-1:0]    coord_t;
    typedef logic signed [3:0]       vel_t;
    typedef logic signed [DW-1:0]    wide_t;
    typedef logic        [DW-1:0]    dist_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        PATROL   = 3'd0,
        ENGAGE   = 3'd1,
        EVADE    = 3'd2,
        RECHARGE = 3'd3,
        DEAD     = 3'd4
    } state_t;

    localparam wide_t            VEL_LIM     = wide_t'(7);
    localparam wide_t            POS_LIM     = wide_t'(BORDER - 1);
    localparam wide_t            GUARD       = wide_t'(BORDER - MARGIN);
    localparam wide_t            ACC_MAX     = wide_t'(MAX_ACC);
    localparam wide_t            ACC_ONE     = wide_t'(1);
    localparam dist_t            FIRE_DIST   = dist_t'(FIRE_RANGE);
    localparam dist_t            DANGER_DIST = dist_t'(DANGER_RANGE);
    localparam logic [7:0]       FIRE_E      = 8'(FIRE_COST);
    localparam logic [7:0]       SHIELD_E    = 8'(SHIELD_COST);
    localparam logic [7:0]       CLOAK_E     = 8'(CLOAK_COST);
    localparam logic [7:0]       RLO_E       = 8'(RECHARGE_LO);
    localparam logic [7:0]       RHI_E       = 8'(RECHARGE_HI);
    localparam logic [AGE_W-1:0] AGE_MAX     = AGE_W'(STALE_LIMIT);
    localparam logic [CD_W-1:0]  CD_LOAD     = CD_W'(FIRE_COOLDOWN);

    function automatic wide_t absW(input wide_t v);
        return v[DW-1] ? -v : v;
    endfunction

    function automatic vel_t satVel(input wide_t v);
        if (v > VEL_LIM)       return vel_t'(VEL_LIM);
        else if (v < -VEL_LIM) return vel_t'(-VEL_LIM);
        else                   return vel_t'(v);
    endfunction

    function automatic coord_t satPos(input wide_t v);
        if (v > POS_LIM)       return coord_t'(POS_LIM);
        else if (v < -POS_LIM) return coord_t'(-POS_LIM);
        else                   return coord_t'(v);
    endfunction

    function automatic acc_t clampAcc(input wide_t v, input wide_t lim);
        if (v > lim)       return acc_t'(lim);
        else if (v < -lim) return acc_t'(-lim);
        else               return acc_t'(v);
    endfunction

    function automatic acc_t signAcc(input wide_t v, input wide_t mag);
        if (v[DW-1])        return acc_t'(-mag);
        else if (v != '0)   return acc_t'(mag);
        else                return '0;
    endfunction

    function automatic logic [1:0] fireDir(input wide_t dx, input wide_t dy);
        if (absW(dx) >= absW(dy)) return dx[DW-1] ? 2'd2 : 2'd0;
        else                      return (!dy[DW-1] && dy != '0) ? 2'd3 : 2'd1;
    endfunction

    coord_t              trkX_q [NUM_SHIPS];
    coord_t              trkX_d [NUM_SHIPS];
    coord_t              trkY_q [NUM_SHIPS];
    coord_t              trkY_d [NUM_SHIPS];
    vel_t                velX_q [NUM_SHIPS];
    vel_t                velX_d [NUM_SHIPS];
    vel_t                velY_q [NUM_SHIPS];
    vel_t                velY_d [NUM_SHIPS];
    logic [AGE_W-1:0]    age_q  [NUM_SHIPS];
    logic [AGE_W-1:0]    age_d  [NUM_SHIPS];
    logic [NUM_SHIPS-1:0] valid_q, valid_d, gone_q, gone_d;

    state_t              state_q [NUM_SHIPS];
    state_t              state_d [NUM_SHIPS];
    logic [CD_W-1:0]     cd_q    [NUM_SHIPS];
    logic [CD_W-1:0]     cd_d    [NUM_SHIPS];

    logic [NUM_SHIPS*ACC_W-1:0] xa_q, xa_d, ya_q, ya_d;
    logic [NUM_SHIPS-1:0]       fire_q, fire_d, shield_q, shield_d, cloak_q, cloak_d;
    logic [NUM_SHIPS*2-1:0]     dir_q, dir_d;

    // Next track state per enemy: refresh when visible, dead-reckon when cloaked, drop permanently when destroyed
    always_comb begin
        for (int e = 0; e < NUM_SHIPS; e++) begin
            trkX_d[e]  = trkX_q[e];
            trkY_d[e]  = trkY_q[e];
            velX_d[e]  = velX_q[e];
            velY_d[e]  = velY_q[e];
            age_d[e]   = age_q[e];
            valid_d[e] = valid_q[e];
            gone_d[e]  = gone_q[e] | enemy_destroyed_i[e];
            if (gone_d[e]) begin
                valid_d[e] = 1'b0;
            end else if (!enemy_cloaked_i[e]) begin
                trkX_d[e]  = coord_t'(enemy_x_i[e*CW +: CW]);
                trkY_d[e]  = coord_t'(enemy_y_i[e*CW +: CW]);
                velX_d[e]  = valid_q[e] ? satVel(wide_t'(trkX_d[e]) - wide_t'(trkX_q[e])) : '0;
                velY_d[e]  = valid_q[e] ? satVel(wide_t'(trkY_d[e]) - wide_t'(trkY_q[e])) : '0;
                age_d[e]   = '0;
                valid_d[e] = 1'b1;
            end else begin
                trkX_d[e] = satPos(wide_t'(trkX_q[e]) + wide_t'(velX_q[e]));
                trkY_d[e] = satPos(wide_t'(trkY_q[e]) + wide_t'(velY_q[e]));
                if (age_q[e] != AGE_MAX) age_d[e] = age_q[e] + 1'b1;
                if (age_d[e] == AGE_MAX) valid_d[e] = 1'b0;
            end
        end
    end

    // Per ship: pick the nearest fresh track, choose the next state, and derive the actions the state registers
    always_comb begin
        wide_t      px, py, dx, dy, ldx, ldy, tgtX, tgtY, tgtVx, tgtVy;
        dist_t      d, best;
        logic       hasTgt;
        logic [7:0] en;
        acc_t       ax, ay;
        xa_d = '0; ya_d = '0; fire_d = '0; shield_d = '0; cloak_d = '0; dir_d = '0;
        px = '0; py = '0; dx = '0; dy = '0; ldx = '0; ldy = '0;
        tgtX = '0; tgtY = '0; tgtVx = '0; tgtVy = '0;
        d = '0; best = '0; hasTgt = 1'b0; en = '0; ax = '0; ay = '0;
        for (int s = 0; s < NUM_SHIPS; s++) begin
            px = wide_t'(coord_t'(x_i[s*CW +: CW]));
            py = wide_t'(coord_t'(y_i[s*CW +: CW]));
            en = energy_i[s*8 +: 8];
            hasTgt = 1'b0; best = '0;
            tgtX = '0; tgtY = '0; tgtVx = '0; tgtVy = '0;
            for (int e = 0; e < NUM_SHIPS; e++) begin
                dx = wide_t'(trkX_d[e]) - px;
                dy = wide_t'(trkY_d[e]) - py;
                d  = dist_t'(absW(dx)) + dist_t'(absW(dy));
                if (valid_d[e] && (!hasTgt || d < best)) begin
                    hasTgt = 1'b1;
                    best   = d;
                    tgtX   = wide_t'(trkX_d[e]);
                    tgtY   = wide_t'(trkY_d[e]);
                    tgtVx  = wide_t'(velX_d[e]);
                    tgtVy  = wide_t'(velY_d[e]);
                end
            end
            ldx = tgtX + tgtVx - px;
            ldy = tgtY + tgtVy - py;

            if (state_q[s] == DEAD || destroyed_i[s])
                state_d[s] = DEAD;
            else if (hasTgt && best <= DANGER_DIST)
                state_d[s] = EVADE;
            else if (en < RLO_E || (state_q[s] == RECHARGE && en < RHI_E))
                state_d[s] = RECHARGE;
            else if (hasTgt && best <= FIRE_DIST && en >= FIRE_E)
                state_d[s] = ENGAGE;
            else
                state_d[s] = PATROL;

            cd_d[s] = (cd_q[s] != '0) ? cd_q[s] - 1'b1 : '0;
            ax = '0;
            ay = '0;
            case (state_d[s])
                EVADE: begin
                    shield_d[s] = (en >= SHIELD_E);
                    cloak_d[s]  = (en < SHIELD_E) && (en >= CLOAK_E);
                    ax = signAcc(px - tgtX, ACC_MAX);
                    ay = signAcc(py - tgtY, ACC_MAX);
                end
                RECHARGE: begin
                    ax = signAcc(-px, ACC_ONE);
                    ay = signAcc(-py, ACC_ONE);
                end
                ENGAGE: begin
                    if (cd_q[s] == '0) begin
                        fire_d[s] = 1'b1;
                        cd_d[s]   = CD_LOAD;
                    end
                    ax = clampAcc(ldx, ACC_MAX);
                    ay = clampAcc(ldy, ACC_MAX);
                end
                PATROL: begin
                    if (hasTgt) begin
                        ax = clampAcc(tgtX - px, ACC_ONE);
                        ay = clampAcc(tgtY - py, ACC_ONE);
                    end
                end
                default: ;
            endcase

            if (state_d[s] != DEAD) begin
                if (px >= GUARD)       ax = acc_t'(-ACC_MAX);
                else if (px <= -GUARD) ax = acc_t'(ACC_MAX);
                if (py >= GUARD)       ay = acc_t'(-ACC_MAX);
                else if (py <= -GUARD) ay = acc_t'(ACC_MAX);
                if (hasTgt) dir_d[s*2 +: 2] = fireDir(ldx, ldy);
            end
            xa_d[s*ACC_W +: ACC_W] = ax;
            ya_d[s*ACC_W +: ACC_W] = ay;
        end
    end

    // Register tracks, state machines, cooldowns and all outputs; synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SHIPS; i++) begin
                trkX_q[i]  <= '0;
                trkY_q[i]  <= '0;
                velX_q[i]  <= '0;
                velY_q[i]  <= '0;
                age_q[i]   <= '0;
                state_q[i] <= PATROL;
                cd_q[i]    <= '0;
            end
            valid_q  <= '0;
            gone_q   <= '0;
            xa_q     <= '0;
            ya_q     <= '0;
            fire_q   <= '0;
            shield_q <= '0;
            cloak_q  <= '0;
            dir_q    <= '0;
        end else begin
            trkX_q   <= trkX_d;
            trkY_q   <= trkY_d;
            velX_q   <= velX_d;
            velY_q   <= velY_d;
            age_q    <= age_d;
            state_q  <= state_d;
            cd_q     <= cd_d;
            valid_q  <= valid_d;
            gone_q   <= gone_d;
            xa_q     <= xa_d;
            ya_q     <= ya_d;
            fire_q   <= fire_d;
            shield_q <= shield_d;
            cloak_q  <= cloak_d;
            dir_q    <= dir_d;
        end
    end

    // Expose the registered state of each ship alongside the outputs it produced
    always_comb begin
        state_dbg_o = '0;
        for (int s = 0; s < NUM_SHIPS; s++) state_dbg_o[s*3 +: 3] = state_q[s];
    end

    assign x_a_o            = xa_q;
    assign y_a_o            = ya_q;
    assign attempt_fire_o   = fire_q;
    assign attempt_shield_o = shield_q;
    assign attempt_cloak_o  = cloak_q;
    assign fire_dir_o       = dir_q;

endmodule

// File: tb/tb_fleet_tactics_ctrl.sv
// tb_fleet_tactics_ctrl: directed scenario bench for fleet_tactics_ctrl.
module tb_fleet_tactics_ctrl;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int AW = 4;
    localparam int PATROL = 0, ENGAGE = 1, EVADE = 2, RECHARGE = 3, DEAD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*CW-1:0]   x, y, enemyX, enemyY;
    logic [N*8-1:0]    energy;
    logic [N-1:0]      destroyed, enemyCloaked, enemyDestroyed;
    logic [N*AW-1:0]   xA, yA;
    logic [N-1:0]      fire, shield, cloak;
    logic [N*2-1:0]    fireDir;
    logic [N*3-1:0]    stateDbg;

    int nCompared   = 0;
    int nMismatched = 0;

    fleet_tactics_ctrl dut (
        .clk(clk), .reset(reset),
        .x_i(x), .y_i(y), .energy_i(energy), .destroyed_i(destroyed),
        .enemy_x_i(enemyX), .enemy_y_i(enemyY),
        .enemy_cloaked_i(enemyCloaked), .enemy_destroyed_i(enemyDestroyed),
        .x_a_o(xA), .y_a_o(yA),
        .attempt_fire_o(fire), .attempt_shield_o(shield), .attempt_cloak_o(cloak),
        .fire_dir_o(fireDir), .state_dbg_o(stateDbg)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Packed view of one ship: {state, x_a, y_a, fire, shield, cloak, dir}
    function automatic logic [15:0] obs(input int s);
        return {stateDbg[s*3 +: 3], xA[s*AW +: AW], yA[s*AW +: AW],
                fire[s], shield[s], cloak[s], fireDir[s*2 +: 2]};
    endfunction

    function automatic logic [15:0] mk(input int st, input int xa, input int ya,
                                       input bit f, input bit sh, input bit c, input int dir);
        return {3'(st), 4'(xa), 4'(ya), f, sh, c, 2'(dir)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setShip(input int i, input int px, input int py, input int en, input bit d);
        x[i*CW +: CW]  = 8'(px);
        y[i*CW +: CW]  = 8'(py);
        energy[i*8 +: 8] = 8'(en);
        destroyed[i]   = d;
    endtask

    task automatic setEnemy(input int i, input int px, input int py, input bit cl, input bit d);
        enemyX[i*CW +: CW] = 8'(px);
        enemyY[i*CW +: CW] = 8'(py);
        enemyCloaked[i]    = cl;
        enemyDestroyed[i]  = d;
    endtask

    task automatic doReset();
        for (int i = 0; i < N; i++) setShip(i, 0, 0, 100, 1'b0);
        setEnemy(0, 0, 0, 1'b0, 1'b0);
        setEnemy(1, 0, 0, 1'b0, 1'b1);
        setEnemy(2, 0, 0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [N*(2*AW+3+2+3)-1:0] got;
        doReset();
        setEnemy(0, 20, 0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        got = {xA, yA, fire, shield, cloak, fireDir, stateDbg};
        nCompared++;
        if (got !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %h want 0", got);
        end
        reset = 1'b0;
    endtask

    task automatic test_engage();
        logic [15:0] got, want;
        logic [3:0]  fireSeq;
        logic [N*(2*AW+3+2+3)-1:0] all;
        fireSeq = 4'b1001;
        doReset();
        setEnemy(0, 20, 0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            got  = obs(0);
            want = mk(ENGAGE, 2, 0, fireSeq[c], 1'b0, 1'b0, 0);
            nCompared++;
            if (got !== want) begin
                nMismatched++;
                $display("[TB] FAIL engage_cycle%0d: got %h want %h", c, got, want);
            end
            if (c == 0) begin
                for (int s = 1; s < N; s++) begin
                    got = obs(s);
                    nCompared++;
                    if (got !== want) begin
                        nMismatched++;
                        $display("[TB] FAIL engage_ship%0d: got %h want %h", s, got, want);
                    end
                end
            end
        end
        reset = 1'b1;
        tick();
        all = {xA, yA, fire, shield, cloak, fireDir, stateDbg};
        nCompared++;
        if (all !== '0) begin
            nMismatched++;
            $display("[TB] FAIL midcooldown_reset: got %h want 0", all);
        end
        reset = 1'b0;
        tick();
        got  = obs(0);
        want = mk(ENGAGE, 2, 0, 1'b1, 1'b0, 1'b0, 0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL cooldown_cleared: got %h want %h", got, want);
        end
    endtask

    task automatic test_evade();
        int          en [5];
        logic [4:0]  shSeq, clSeq;
        logic [15:0] got, want;
        en = '{100, 25, 24, 15, 14};
        shSeq = 5'b00011;
        clSeq = 5'b01100;
        doReset();
        setEnemy(0, 5, 3, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            setShip(0, 0, 0, en[c], 1'b0);
            tick();
            got  = obs(0);
            want = mk(EVADE, -2, -2, 1'b0, shSeq[c], clSeq[c], 0);
            nCompared++;
            if (got !== want) begin
                nMismatched++;
                $display("[TB] FAIL evade_energy%0d: got %h want %h", en[c], got, want);
            end
        end
    endtask

    task automatic test_track();
        int          ex [9];
        logic [8:0]  clk9;
        logic [15:0] want [9];
        logic [15:0] got;
        ex    = '{10, 12, 12, 12, 12, 12, 12, 12, 12};
        clk9  = 9'b111111100;
        want[0] = mk(ENGAGE, -2, -2, 1'b1, 1'b0, 1'b0, 1);
        want[1] = mk(ENGAGE, -2, -2, 1'b0, 1'b0, 1'b0, 1);
        want[2] = mk(ENGAGE, -1, -2, 1'b0, 1'b0, 1'b0, 1);
        want[3] = mk(ENGAGE,  1, -2, 1'b1, 1'b0, 1'b0, 1);
        want[4] = mk(ENGAGE,  2, -2, 1'b0, 1'b0, 1'b0, 1);
        want[5] = mk(ENGAGE,  2, -2, 1'b0, 1'b0, 1'b0, 1);
        want[6] = mk(ENGAGE,  2, -2, 1'b1, 1'b0, 1'b0, 1);
        want[7] = mk(PATROL,  0,  0, 1'b0, 1'b0, 1'b0, 0);
        want[8] = mk(PATROL,  0,  0, 1'b0, 1'b0, 1'b0, 0);
        doReset();
        setShip(0, 17, 20, 100, 1'b0);
        for (int c = 0; c < 9; c++) begin
            setEnemy(0, ex[c], 0, clk9[c], 1'b0);
            tick();
            got = obs(0);
            nCompared++;
            if (got !== want[c]) begin
                nMismatched++;
                $display("[TB] FAIL track_cycle%0d: got %h want %h", c, got, want[c]);
            end
        end
    endtask

    task automatic test_recharge();
        int          en [7];
        int          ex [7];
        logic [15:0] want [7];
        logic [15:0] got;
        en = '{25, 19, 59, 60, 19, 20, 20};
        ex = '{20, 20, 20, 20, 20, 20, 10};
        want[0] = mk(PATROL,    1,  1, 1'b0, 1'b0, 1'b0, 0);
        want[1] = mk(RECHARGE, -1,  1, 1'b0, 1'b0, 1'b0, 0);
        want[2] = mk(RECHARGE, -1,  1, 1'b0, 1'b0, 1'b0, 0);
        want[3] = mk(ENGAGE,    2,  2, 1'b1, 1'b0, 1'b0, 0);
        want[4] = mk(RECHARGE, -1,  1, 1'b0, 1'b0, 1'b0, 0);
        want[5] = mk(RECHARGE, -1,  1, 1'b0, 1'b0, 1'b0, 0);
        want[6] = mk(EVADE,    -2, -2, 1'b0, 1'b0, 1'b1, 3);
        doReset();
        for (int c = 0; c < 7; c++) begin
            setShip(0, 5, -4, en[c], 1'b0);
            setEnemy(0, ex[c], 0, 1'b0, 1'b0);
            tick();
            got = obs(0);
            nCompared++;
            if (got !== want[c]) begin
                nMismatched++;
                $display("[TB] FAIL recharge_step%0d: got %h want %h", c, got, want[c]);
            end
        end
    endtask

    task automatic test_border_dead();
        logic [15:0] got, want;
        doReset();
        setShip(0, 30, 0, 100, 1'b0);
        setEnemy(0, 40, 0, 1'b0, 1'b0);
        tick();
        got = obs(0); want = mk(EVADE, -2, 0, 1'b0, 1'b1, 1'b0, 0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL border_evade: got %h want %h", got, want);
        end
        setShip(0, 30, -30, 100, 1'b0);
        setEnemy(0, 45, -50, 1'b0, 1'b0);
        tick();
        got = obs(0); want = mk(ENGAGE, -2, 2, 1'b1, 1'b0, 1'b0, 1);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL border_override: got %h want %h", got, want);
        end
        setShip(0, 30, -30, 100, 1'b1);
        tick();
        got = obs(0); want = mk(DEAD, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL dead_enter: got %h want %h", got, want);
        end
        setShip(0, 30, -30, 100, 1'b0);
        tick();
        got = obs(0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL dead_sticky: got %h want %h", got, want);
        end
    endtask

    task automatic test_tie();
        logic [15:0] got, want;
        doReset();
        setEnemy(0, 10, 0, 1'b0, 1'b0);
        setEnemy(1, 0, -10, 1'b0, 1'b0);
        tick();
        got = obs(0); want = mk(EVADE, -2, 0, 1'b0, 1'b1, 1'b0, 0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL tie_lowest_index: got %h want %h", got, want);
        end
        setEnemy(0, 10, 0, 1'b0, 1'b1);
        tick();
        got = obs(0); want = mk(EVADE, 0, 2, 1'b0, 1'b1, 1'b0, 1);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL tie_after_destroy: got %h want %h", got, want);
        end
        setEnemy(0, 10, 0, 1'b0, 1'b0);
        tick();
        got = obs(0);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL enemy_gone_sticky: got %h want %h", got, want);
        end
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        x = '0; y = '0; energy = '0; destroyed = '0;
        enemyX = '0; enemyY = '0; enemyCloaked = '0; enemyDestroyed = '0;
        test_reset();
        test_engage();
        test_evade();
        test_track();
        test_recharge();
        test_border_dead();
        test_tie();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
